// File: rtl/log_product_accumulator.sv
// rtl/log_product_accumulator.sv - dot-product accumulator for log-multiplier products
// Sums up to VEC_LEN products per vector with sticky saturation; result held until out_ready.
module log_product_accumulator #(
  parameter int PROD_W  = 16,
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = PROD_W + $clog2(VEC_LEN),
  parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_count
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_sat_q, out_sat_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_n;
  logic             sat_n;
  logic             vec_end;

  assign in_ready = (state_q == ST_ACCUM) && !flush;

  always_comb begin
    sum     = {1'b0, acc_q} + (ACC_W + 1)'(in_product);
    // Once saturated, the vector stays clamped even if later products are zero.
    sat_n   = sum[ACC_W] | sat_q;
    acc_n   = sat_n ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    vec_end = (cnt_q == CNT_W'(VEC_LEN - 1)) || in_last;

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;

    case (state_q)
      ST_ACCUM: begin
        if (flush) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (in_valid) begin
          if (vec_end) begin
            out_sum_d   = acc_n;
            out_sat_d   = sat_n;
            out_count_d = cnt_q + CNT_W'(1);
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
          end else begin
            acc_d = acc_n;
            sat_d = sat_n;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_log_product_accumulator.sv
// tb/tb_log_product_accumulator.sv - directed bench for log_product_accumulator
// Drives a default (ACC_W=19) and a narrow (ACC_W=16) instance with identical stimulus.
module tb_log_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_last, out_ready;
  logic [15:0] in_product;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [18:0] out_sum_a;
  logic [3:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [15:0] out_sum_b;
  logic [3:0]  out_count_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  log_product_accumulator u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_sat(out_sat_a), .out_count(out_count_a)
  );

  log_product_accumulator #(.ACC_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_sat(out_sat_b), .out_count(out_count_b)
  );

  typedef struct {
    logic [15:0] prod;
    logic        last;
    logic        done;
    logic [18:0] sum_a;
    logic        sat_a;
    logic [15:0] sum_b;
    logic        sat_b;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_mid(input logic [15:0] p, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.prod = p; v.last = 1'b0; v.done = 1'b0;
      v.sum_a = '0; v.sat_a = 1'b0; v.sum_b = '0; v.sat_b = 1'b0; v.cnt = '0;
      vecs.push_back(v);
    end
  endtask

  task automatic add_end(input logic [15:0] p, input logic l, input logic [18:0] sa, input logic ta,
                         input logic [15:0] sb, input logic tb, input logic [3:0] c);
    vec_t v;
    v.prod = p; v.last = l; v.done = 1'b1;
    v.sum_a = sa; v.sat_a = ta; v.sum_b = sb; v.sat_b = tb; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic drive_beat(input logic [15:0] p, input logic l);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = l;
    #1;
    chk("in_ready_a before beat", in_ready_a, 1);
    chk("in_ready_b before beat", in_ready_b, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [18:0] sa, input logic ta,
                              input logic [15:0] sb, input logic tb, input logic [3:0] c);
    chk({tag, " out_valid_a"}, out_valid_a, 1);
    chk({tag, " out_valid_b"}, out_valid_b, 1);
    chk({tag, " out_sum_a"}, out_sum_a, sa);
    chk({tag, " out_sat_a"}, out_sat_a, ta);
    chk({tag, " out_count_a"}, out_count_a, c);
    chk({tag, " out_sum_b"}, out_sum_b, sb);
    chk({tag, " out_sat_b"}, out_sat_b, tb);
    chk({tag, " out_count_b"}, out_count_b, c);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    out_ready = 1'b0; in_product = 16'h1000;

    // Reset held with in_valid asserted
    tick();
    tick();
    chk("reset in_ready", in_ready_a, 1);
    chk("reset out_valid", out_valid_a, 0);
    chk("reset out_sum", out_sum_a, 0);
    chk("reset out_count", out_count_a, 0);
    chk("reset out_sat", out_sat_a, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    out_ready = 1'b1;
    tick();

    add_mid(16'h1000, 7);
    add_end(16'h1000, 1'b0, 19'h08000, 1'b0, 16'h8000, 1'b0, 4'd8);
    add_mid(16'd5, 1); add_mid(16'd7, 1);
    add_end(16'd9, 1'b1, 19'd21, 1'b0, 16'd21, 1'b0, 4'd3);
    add_mid(16'd1, 1);
    add_end(16'd1, 1'b1, 19'd2, 1'b0, 16'd2, 1'b0, 4'd2);
    add_mid(16'd0, 1);
    add_end(16'd0, 1'b1, 19'd0, 1'b0, 16'd0, 1'b0, 4'd2);
    add_mid(16'hFFFF, 7);
    add_end(16'hFFFF, 1'b0, 19'h7FFF8, 1'b0, 16'hFFFF, 1'b1, 4'd8);
    add_mid(16'hFFFF, 2);
    add_end(16'hFFFF, 1'b1, 19'h2FFFD, 1'b0, 16'hFFFF, 1'b1, 4'd3);
    add_mid(16'h8000, 2);
    add_end(16'h0000, 1'b1, 19'h10000, 1'b0, 16'hFFFF, 1'b1, 4'd3);
    add_end(16'd1, 1'b1, 19'd1, 1'b0, 16'd1, 1'b0, 4'd1);
    add_mid(16'hFFFE, 1);
    add_end(16'd1, 1'b1, 19'hFFFF, 1'b0, 16'hFFFF, 1'b0, 4'd2);
    add_mid(16'd1, 7);
    add_end(16'd1, 1'b1, 19'd8, 1'b0, 16'd8, 1'b0, 4'd8);

    foreach (vecs[i]) begin
      drive_beat(vecs[i].prod, vecs[i].last);
      if (vecs[i].done) begin
        check_result($sformatf("vec%0d", i), vecs[i].sum_a, vecs[i].sat_a,
                     vecs[i].sum_b, vecs[i].sat_b, vecs[i].cnt);
        chk("hold in_ready", in_ready_a, 0);
        tick();
        chk("out_valid one cycle", out_valid_a, 0);
      end else begin
        chk($sformatf("vec%0d mid out_valid", i), out_valid_a, 0);
      end
    end

    // Backpressure: held result survives in_valid, flush and 10 stalled cycles
    out_ready = 1'b0;
    drive_beat(16'd2, 1'b0);
    drive_beat(16'd2, 1'b0);
    drive_beat(16'd2, 1'b1);
    check_result("bp", 19'd6, 1'b0, 16'd6, 1'b0, 4'd3);
    in_valid = 1'b1; in_product = 16'h0100; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      flush = (c == 5);
      #1;
      chk("bp in_ready", in_ready_a, 0);
      tick();
      chk("bp out_valid", out_valid_a, 1);
      chk("bp out_sum", out_sum_a, 6);
      chk("bp out_count", out_count_a, 3);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp release out_valid", out_valid_a, 0);
    chk("bp release in_ready", in_ready_a, 1);
    tick();
    check_result("bp next", 19'h100, 1'b0, 16'h100, 1'b0, 4'd1);
    in_valid = 1'b0; in_last = 1'b0;
    tick();

    // Flush mid-vector, then reset mid-vector
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 3; k++) drive_beat(16'd4, 1'b0);
      in_valid = 1'b1; in_product = 16'd4;
      if (pass == 0) begin
        flush = 1'b1;
        #1;
        chk("flush in_ready", in_ready_a, 0);
      end else begin
        rst_n = 1'b0;
      end
      tick();
      flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
      chk("abort out_valid", out_valid_a, 0);
      for (int k = 0; k < 7; k++) drive_beat(16'd1, 1'b0);
      drive_beat(16'd1, 1'b0);
      check_result(pass == 0 ? "flush" : "rst", 19'd8, 1'b0, 16'd8, 1'b0, 4'd8);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
